// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
package ram_arb_pkg;

  localparam int NUM_REQ    = 2;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 1;

  // One transaction walks IDLE -> ACCESS -> RESP -> IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/ram_arb_rr_pick.sv
// Combinational winner select for two requesters.
// Default: a tie goes to the requester named by ptr (round robin).
// With RAM_ARB_FIXED_PRIO_EN defined: a tie always goes to requester 0 and
// ptr is ignored.
module ram_arb_rr_pick
  import ram_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               ptr,
  output logic [NUM_REQ-1:0] win
);

`ifdef RAM_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ptr;

  // Requester 0 beats requester 1 whenever both ask.
  always_comb begin
    win    = '0;
    win[0] = req[0];
    win[1] = req[1] & ~req[0];
  end
`else
  // A lone requester wins; a tie goes to the pointer holder.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (otherwise a latch is inferred).
    win = req;
    if (req == 2'b11) begin
      win = ptr ? 2'b10 : 2'b01;
    end
  end
`endif

endmodule

// File: rtl/ram_rr_arbiter.sv
// Two-requester sequencer for a small synchronous RAM. One transaction
// takes three cycles: grant + RAM strobe, RAM access, then ack (+ read data).
// All outputs are registered. Optional macro RAM_ARB_FIXED_PRIO_EN replaces
// round-robin tie breaking with fixed priority for requester 0.
module ram_rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic [NUM_REQ-1:0]  we_i,
  input  logic [ADDR_W-1:0]   addr0_i,
  input  logic [ADDR_W-1:0]   addr1_i,
  input  logic [DATA_W-1:0]   wdata0_i,
  input  logic [DATA_W-1:0]   wdata1_i,
  output logic [NUM_REQ-1:0]  gnt_o,
  output logic [NUM_REQ-1:0]  ack_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                mem_en_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  win_q, win_d;      // requester owning the current transaction
  logic [NUM_REQ-1:0]  win;
  logic [NUM_REQ-1:0]  gnt_d, ack_d;
  logic [DATA_W-1:0]   rdata_d, mem_wdata_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic                mem_en_d, mem_we_d;
  logic                ptr_q;

`ifdef RAM_ARB_FIXED_PRIO_EN
  assign ptr_q = 1'b0;
`else
  // Round-robin pointer: after each completed transaction the other requester
  // is preferred on the next tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (state_q == RESP) begin
      ptr_q <= win_q[0];
    end
  end
`endif

  ram_arb_rr_pick u_pick (
    .req (req_i),
    .ptr (ptr_q),
    .win (win)
  );

  // Next-state and next-output logic; command registers hold between grants.
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    gnt_d       = '0;
    ack_d       = '0;
    rdata_d     = rdata_o;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_o;
    mem_addr_d  = mem_addr_o;
    mem_wdata_d = mem_wdata_o;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d  = ACCESS;
          win_d    = win;
          gnt_d    = win;
          mem_en_d = 1'b1;
          if (win[1]) begin
            mem_we_d    = we_i[1];
            mem_addr_d  = addr1_i;
            mem_wdata_d = wdata1_i;
          end else begin
            mem_we_d    = we_i[0];
            mem_addr_d  = addr0_i;
            mem_wdata_d = wdata0_i;
          end
        end
      end
      ACCESS: begin
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
        ack_d   = win_q;
        if (!mem_we_o) begin
          rdata_d = mem_rdata_i;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      win_q       <= '0;
      gnt_o       <= '0;
      ack_o       <= '0;
      rdata_o     <= '0;
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q     <= state_d;
      win_q       <= win_d;
      gnt_o       <= gnt_d;
      ack_o       <= ack_d;
      rdata_o     <= rdata_d;
      mem_en_o    <= mem_en_d;
      mem_we_o    <= mem_we_d;
      mem_addr_o  <= mem_addr_d;
      mem_wdata_o <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Directed self-checking bench for ram_rr_arbiter with a behavioural
// 2x8 synchronous RAM attached to the command port.
module tb_ram_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_i, we_i;
  logic [0:0] addr0_i, addr1_i;
  logic [7:0] wdata0_i, wdata1_i;
  logic [1:0] gnt_o, ack_o;
  logic [7:0] rdata_o;
  logic       mem_en_o, mem_we_o;
  logic [0:0] mem_addr_o;
  logic [7:0] mem_wdata_o;
  logic [7:0] mem_rdata_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_rr_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr0_i     (addr0_i),
    .addr1_i     (addr1_i),
    .wdata0_i    (wdata0_i),
    .wdata1_i    (wdata1_i),
    .gnt_o       (gnt_o),
    .ack_o       (ack_o),
    .rdata_o     (rdata_o),
    .mem_en_o    (mem_en_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i)
  );

  // Behavioural RAM: write or registered read on the strobed edge.
  logic [7:0] ram [2];
  always @(posedge clk) begin
    if (mem_en_o) begin
      if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
      else          mem_rdata_i     <= ram[mem_addr_o];
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    req_i = '0; we_i = '0;
    addr0_i = '0; addr1_i = '0; wdata0_i = '0; wdata1_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs one transaction for requester k and reports what was observed.
  // Latencies are counted in cycles from the cycle the request is presented.
  task automatic run_txn(input int k, input logic we, input logic [0:0] addr,
                         input logic [7:0] wd,
                         output logic [1:0] g, output int glat,
                         output logic men, output logic mwe,
                         output logic [0:0] maddr, output logic [7:0] mwd,
                         output logic [1:0] a, output int alat,
                         output logic [7:0] rd);
    @(negedge clk);
    req_i[k] = 1'b1;
    we_i[k]  = we;
    if (k == 0) begin addr0_i = addr; wdata0_i = wd; end
    else        begin addr1_i = addr; wdata1_i = wd; end
    g = '0; glat = 0; men = 0; mwe = 0; maddr = '0; mwd = '0;
    a = '0; alat = 0; rd = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (gnt_o != 2'b00) begin
        g = gnt_o; glat = c; men = mem_en_o; mwe = mem_we_o;
        maddr = mem_addr_o; mwd = mem_wdata_o;
        break;
      end
    end
    req_i[k] = 1'b0;
    for (int c = glat + 1; c <= glat + 10; c++) begin
      @(negedge clk);
      if (ack_o != 2'b00) begin
        a = ack_o; alat = c; rd = rdata_o;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic bad;
    apply_reset();
    checks++;
    if ({gnt_o, ack_o, rdata_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o} !== '0) begin
      errors++;
      $display("FAIL reset_state got gnt=%b ack=%b rdata=%h en=%b we=%b addr=%b wd=%h exp all zero",
               gnt_o, ack_o, rdata_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o);
    end
    // Start a write and abort it mid-ACCESS.
    req_i[0] = 1'b1; we_i[0] = 1'b1; addr0_i = 1'b1; wdata0_i = 8'h5A;
    @(negedge clk);
    checks++;
    if (gnt_o !== 2'b01 || mem_en_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_gnt got gnt=%b en=%b exp gnt=01 en=1", gnt_o, mem_en_o);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({gnt_o, ack_o, rdata_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o} !== '0) begin
      errors++;
      $display("FAIL reset_async got gnt=%b ack=%b rdata=%h en=%b we=%b addr=%b wd=%h exp all zero",
               gnt_o, ack_o, rdata_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o);
    end
    req_i = '0; we_i = '0;
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (ack_o !== 2'b00 || gnt_o !== 2'b00 || mem_en_o !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_after got activity=%b exp 0", bad);
    end
  endtask

  task automatic test_write_read();
    logic [1:0] g, a; int glat, alat; logic men, mwe; logic [0:0] ma; logic [7:0] mwd, rd;
    apply_reset();
    run_txn(0, 1'b1, 1'b0, 8'hAA, g, glat, men, mwe, ma, mwd, a, alat, rd);
    checks++;
    if (g !== 2'b01 || glat !== 1) begin
      errors++;
      $display("FAIL wr_gnt got gnt=%b at cycle %0d exp 01 at 1", g, glat);
    end
    checks++;
    if ({men, mwe, ma, mwd} !== {1'b1, 1'b1, 1'b0, 8'hAA}) begin
      errors++;
      $display("FAIL wr_cmd got en=%b we=%b addr=%b wd=%h exp 1 1 0 aa", men, mwe, ma, mwd);
    end
    checks++;
    if (a !== 2'b01 || alat !== 3 || rd !== 8'h00) begin
      errors++;
      $display("FAIL wr_ack got ack=%b at %0d rdata=%h exp 01 at 3 rdata=00", a, alat, rd);
    end
    run_txn(0, 1'b0, 1'b0, 8'h00, g, glat, men, mwe, ma, mwd, a, alat, rd);
    checks++;
    if (g !== 2'b01 || mwe !== 1'b0 || ma !== 1'b0) begin
      errors++;
      $display("FAIL rd_cmd got gnt=%b we=%b addr=%b exp 01 0 0", g, mwe, ma);
    end
    checks++;
    if (a !== 2'b01 || alat !== 3 || rd !== 8'hAA) begin
      errors++;
      $display("FAIL rd_data got ack=%b at %0d rdata=%h exp 01 at 3 rdata=aa", a, alat, rd);
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] seen [2];
    int n;
    logic [1:0] g, a; int glat, alat; logic men, mwe; logic [0:0] ma; logic [7:0] mwd, rd;
    apply_reset();
    @(negedge clk);
    req_i = 2'b11; we_i = 2'b11;
    addr0_i = 1'b1; wdata0_i = 8'hFF;
    addr1_i = 1'b1; wdata1_i = 8'h0F;
    n = 0; seen[0] = '0; seen[1] = '0;
    for (int c = 0; c < 20 && n < 2; c++) begin
      @(negedge clk);
      if (gnt_o != 2'b00) begin
        seen[n] = gnt_o;
        req_i = req_i & ~gnt_o;
        n++;
      end
    end
    req_i = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (seen[0] !== 2'b01 || seen[1] !== 2'b10) begin
      errors++;
      $display("FAIL simul_order got %b,%b exp 01,10", seen[0], seen[1]);
    end
    run_txn(0, 1'b0, 1'b1, 8'h00, g, glat, men, mwe, ma, mwd, a, alat, rd);
    checks++;
    if (a !== 2'b01 || rd !== 8'h0F) begin
      errors++;
      $display("FAIL simul_raw got ack=%b rdata=%h exp 01 0f", a, rd);
    end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_g;
    logic [1:0] seen [6];
    int at [6];
    int n;
    apply_reset();
    @(negedge clk);
    req_i = 2'b11; we_i = 2'b00; addr0_i = 1'b0; addr1_i = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin seen[i] = '0; at[i] = 0; end
    for (int c = 1; c <= 40 && n < 6; c++) begin
      @(negedge clk);
      if (gnt_o != 2'b00) begin
        seen[n] = gnt_o; at[n] = c; n++;
      end
    end
    req_i = '0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      exp_g = 2'b01;
`else
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
      checks++;
      if (seen[i] !== exp_g || at[i] !== 1 + 3 * i) begin
        errors++;
        $display("FAIL fair_gnt%0d got %b at cycle %0d exp %b at %0d",
                 i, seen[i], at[i], exp_g, 1 + 3 * i);
      end
    end
  endtask

  task automatic test_addr_isolation();
    logic [1:0] g, a; int glat, alat; logic men, mwe; logic [0:0] ma; logic [7:0] mwd, rd;
    apply_reset();
    run_txn(0, 1'b1, 1'b0, 8'h55, g, glat, men, mwe, ma, mwd, a, alat, rd);
    run_txn(1, 1'b1, 1'b1, 8'h33, g, glat, men, mwe, ma, mwd, a, alat, rd);
    checks++;
    if (g !== 2'b10 || a !== 2'b10 || ma !== 1'b1 || mwd !== 8'h33) begin
      errors++;
      $display("FAIL iso_wr1 got gnt=%b ack=%b addr=%b wd=%h exp 10 10 1 33", g, a, ma, mwd);
    end
    run_txn(0, 1'b0, 1'b0, 8'h00, g, glat, men, mwe, ma, mwd, a, alat, rd);
    checks++;
    if (a !== 2'b01 || rd !== 8'h55) begin
      errors++;
      $display("FAIL iso_rd0 got ack=%b rdata=%h exp 01 55", a, rd);
    end
    run_txn(1, 1'b0, 1'b1, 8'h00, g, glat, men, mwe, ma, mwd, a, alat, rd);
    checks++;
    if (a !== 2'b10 || rd !== 8'h33) begin
      errors++;
      $display("FAIL iso_rd1 got ack=%b rdata=%h exp 10 33", a, rd);
    end
  endtask

  task automatic test_back_to_back();
    int ack_at, gnt2_at, gcount;
    logic [1:0] g2;
    apply_reset();
    @(negedge clk);
    req_i[1] = 1'b1; we_i[1] = 1'b0; addr1_i = 1'b1;
    ack_at = 0; gnt2_at = 0; gcount = 0; g2 = '0;
    for (int c = 1; c <= 20 && gnt2_at == 0; c++) begin
      @(negedge clk);
      if (ack_o != 2'b00 && ack_at == 0) ack_at = c;
      if (gnt_o != 2'b00) begin
        gcount++;
        if (gcount == 2) begin gnt2_at = c; g2 = gnt_o; end
      end
    end
    req_i = '0;
    repeat (4) @(negedge clk);
    checks++;
    if (ack_at !== 3 || gnt2_at !== 4 || g2 !== 2'b10) begin
      errors++;
      $display("FAIL b2b got ack at %0d, gnt2=%b at %0d exp ack at 3, gnt2=10 at 4",
               ack_at, g2, gnt2_at);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_i = '0; we_i = '0;
    addr0_i = '0; addr1_i = '0; wdata0_i = '0; wdata1_i = '0;
    test_reset();
    test_write_read();
    test_simultaneous();
    test_fairness();
    test_addr_isolation();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_rr_arbiter.md
Name: ram_rr_arbiter

Overview:
- Sequences a small synchronous RAM (2 words x 8 bits, 1-bit address) on behalf of two requesters.
- Arbitrates between the requesters round-robin and drives a single RAM command port.
- Returns an acknowledge for every transaction, plus read data for reads.
- Sits between requester masters (e.g. test sequencers, DMA stubs) and the RAM array; it is the only master of the RAM port.

Parameters:
- DATA_W, 8: data width of requester and RAM ports.
- ADDR_W, 1: address width; RAM depth is 2**ADDR_W.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- req_i  in  2  per-requester request; bit k belongs to requester k
- we_i  in  2  per-requester write enable (1 = write, 0 = read)
- addr0_i / addr1_i  in  ADDR_W  requester address
- wdata0_i / wdata1_i  in  DATA_W  requester write data
- gnt_o  out  2  one-hot grant, one-cycle pulse
- ack_o  out  2  one-hot transaction-complete pulse
- rdata_o  out  DATA_W  read data; valid when ack_o pulses for a read
- mem_en_o  out  1  RAM access strobe
- mem_we_o  out  1  RAM write enable (0 = read)
- mem_addr_o  out  ADDR_W  RAM address
- mem_wdata_o  out  DATA_W  RAM write data
- mem_rdata_i  in  DATA_W  RAM read data; valid the cycle after mem_en_o with mem_we_o=0

Behaviour:
- All outputs are registered.
- Reset values:
  - gnt_o=0, ack_o=0, rdata_o=0, mem_en_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
  - Priority pointer = 0 (requester 0 preferred).
  - State = IDLE.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If req_i==0, stay in IDLE.
  - Otherwise pick a winner. A single requester always wins. If both request, the pointer holder wins.
  - Latch the winner's we/addr/wdata.
  - Next cycle: state=ACCESS, gnt_o[winner]=1, mem_en_o=1, mem_we_o/mem_addr_o/mem_wdata_o driven from the latched command.
- ACCESS (exactly 1 cycle):
  - The RAM performs the write or read at the closing edge.
  - Next state = RESP; gnt_o and mem_en_o return to 0.
- RESP (exactly 1 cycle):
  - For reads, sample mem_rdata_i into rdata_o.
  - For writes, rdata_o holds its previous value.
  - Next cycle: ack_o[winner]=1 and state=IDLE.
  - Pointer moves to the non-winner (round robin).
- Latency: request seen in cycle 0 → gnt in cycle 1 → RAM access at end of cycle 1 → ack/rdata in cycle 3.
  - Peak throughput is one transaction per 3 cycles.
  - The IDLE cycle that carries ack_o may also arbitrate the next request.
- Requester protocol:
  - Hold req/we/addr/wdata stable until gnt_o[k] is seen.
  - Drop req the cycle after gnt_o[k] unless another transaction is wanted.
  - A req still high in the ack cycle is treated as a new request.
- Read-after-write from another requester returns the new data, because accesses are serialised.
- Ack outputs: ack_o and gnt_o are each one-hot or zero, never both bits set.
- req_i changes while in ACCESS or RESP are ignored until IDLE.
- Reset mid-transaction:
  - Abort immediately and return all outputs to reset values.
  - No ack is issued.
  - A write already committed by the RAM stays committed.

Optional Feature:
- Macro RAM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. Requester 0 always wins a tie and the pointer is not implemented.
- Undefined (default): round-robin as specified above.

Decomposition:
- Package ram_arb_pkg:
  - State enum typedef (IDLE, ACCESS, RESP).
  - Constant NUM_REQ=2.
  - Default DATA_W and ADDR_W constants.
- One combinational sub-module, ram_arb_rr_pick: inputs req[1:0] and ptr; output one-hot win[1:0]. It also contains the fixed-priority variant under the macro.

Test Plan:
- Reset: assert rst mid-ACCESS → all outputs 0 within the same cycle (async). After release, idle with no ack.
- Single write then read on requester 0: write addr 0 data 8'hAA → gnt_o=01 at cycle 1, mem_we_o=1, ack_o=01 at cycle 3. Then read addr 0 → ack_o=01 with rdata_o=8'hAA.
- Simultaneous requests after reset: req0 writes addr 1 data 8'hFF, req1 writes addr 1 data 8'h0F.
  - Round-robin: req0 granted first, req1 second.
  - A subsequent read of addr 1 returns 8'h0F.
- Fairness: both req held continuously for 6 transactions → grants alternate 01,10,01,10,01,10. With RAM_ARB_FIXED_PRIO_EN: all six are 01.
- Address isolation: write 8'h55 to addr 0 and 8'h33 to addr 1 via different requesters → reads return 8'h55 and 8'h33 respectively.
- Back-to-back: req1 held high through its ack cycle → second gnt_o=10 in the cycle after the ack, with no extra idle cycle.
